debug_mem_ctrl: RTL and testbench

- Parametrised debug controller for block-RAM inspection on the Nexys board.
- Switch-sourced address/data registers, single write/read, and ranged pattern fill with optional readback verify.
- 32-bit selectable display word for the 8-digit seven-segment controller.
- Sits between the debounced-button/switch input stage and a top-level single-port BRAM of configurable width and depth.

---
 rtl/debug_mem_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_debug_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_ctrl.sv
// debug_mem_ctrl
//   Debug controller for inspecting a single-port block RAM from the board's
//   switches and buttons. Switch values are captured into start/end/data
//   registers. The operations are a single write, a single read, and a ranged
//   pattern fill. A 32-bit display word feeds the seven-segment controller.
//
//   Build option: define DEBUG_MEM_VERIFY_EN to add a readback verify pass
//   after every fill. The verify pass counts mismatches and latches the first
//   failing address. Without the macro, both of those values are tied to 0.
//
// Ports
//   CLK_100_I     100 MHz system clock
//   RST_I         synchronous active-high reset
//   SW_I          switch bus, low bits used for captures
//   CMD_ADDR_I    pulse: capture start address
//   CMD_END_I     pulse: capture end address
//   CMD_DATA_I    pulse: capture data / fill seed
//   CMD_WR_I      pulse: single write of data to start
//   CMD_RD_I      pulse: single read of start into rd_reg
//   CMD_FILL_I    pulse: fill start..end (wrapping) with pattern MODE_I
//   ABORT_I       pulse: abandon the active operation
//   MODE_I        fill pattern: 00 const, 01 incrementing, 10 address, 11 zero
//   DISP_SEL_I    display source select
//   MEM_RDATA_I   BRAM read data, valid RD_LAT cycles after the address
//   MEM_WE_O      BRAM write enable
//   MEM_ADDR_O    BRAM address
//   MEM_WDATA_O   BRAM write data
//   BUSY_O        operation in progress
//   DONE_O        one-cycle pulse on normal completion
//   ERR_CNT_O     saturating verify mismatch count
//   DISP_O        registered display word
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | accept captures and commands
// WR1       | single write cycle, WE high, DONE pulses
// RD_WAIT   | address held, waiting RD_LAT cycles for read data
// FILL      | one pattern write per cycle from start to end
// VER_RUN   | one readback per cycle from start to end (verify builds only)
// VER_DRAIN | wait for the last RD_LAT read results (verify builds only)

module debug_mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SW_W   = 16,
    parameter int RD_LAT = 1
) (
    input  logic              CLK_100_I,
    input  logic              RST_I,
    input  logic [SW_W-1:0]   SW_I,
    input  logic              CMD_ADDR_I,
    input  logic              CMD_END_I,
    input  logic              CMD_DATA_I,
    input  logic              CMD_WR_I,
    input  logic              CMD_RD_I,
    input  logic              CMD_FILL_I,
    input  logic              ABORT_I,
    input  logic [1:0]        MODE_I,
    input  logic [1:0]        DISP_SEL_I,
    input  logic [DATA_W-1:0] MEM_RDATA_I,
    output logic              MEM_WE_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic [DATA_W-1:0] MEM_WDATA_O,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic [15:0]       ERR_CNT_O,
    output logic [31:0]       DISP_O
);

    localparam int LAT_W = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR1       = 3'd1,
        RD_WAIT   = 3'd2,
        FILL      = 3'd3
`ifdef DEBUG_MEM_VERIFY_EN
        ,
        VER_RUN   = 3'd4,
        VER_DRAIN = 3'd5
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] rem_q;
    logic [ADDR_W-1:0] first_err_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_reg_q;
    logic [DATA_W-1:0] pat_q;
    logic [1:0]        mode_q;
    logic [15:0]       word_cnt_q;
    logic [15:0]       err_cnt_q;
    logic [LAT_W-1:0]  lat_cnt_q;

    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] pat_nxt;
    logic [DATA_W-1:0] pat_first;

    // Pattern word for the first address of a pass.
    function automatic logic [DATA_W-1:0] first_pat(input logic [1:0]        mode,
                                                    input logic [DATA_W-1:0] seed,
                                                    input logic [ADDR_W-1:0] addr);
        case (mode)
            2'b10:   return DATA_W'(addr);
            2'b11:   return '0;
            default: return seed;
        endcase
    endfunction

    // Pattern word for the next address. Fill and verify share this, so the
    // expected data is produced exactly as it was written.
    function automatic logic [DATA_W-1:0] next_pat(input logic [1:0]        mode,
                                                   input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] seed,
                                                   input logic [ADDR_W-1:0] addr);
        case (mode)
            2'b00:   return seed;
            2'b01:   return cur + DATA_W'(1);
            2'b10:   return DATA_W'(addr);
            default: return '0;
        endcase
    endfunction

    assign addr_nxt  = MEM_ADDR_O + ADDR_W'(1);
    assign pat_nxt   = next_pat(mode_q, pat_q, data_q, addr_nxt);
    assign pat_first = first_pat(MODE_I, data_q, start_q);
    assign ERR_CNT_O = err_cnt_q;

    always_ff @(posedge CLK_100_I) begin
        if (RST_I) begin
            state       <= IDLE;
            start_q     <= '0;
            end_q       <= '0;
            data_q      <= '0;
            rd_reg_q    <= '0;
            rem_q       <= '0;
            pat_q       <= '0;
            mode_q      <= '0;
            word_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            MEM_WE_O    <= 1'b0;
            MEM_ADDR_O  <= '0;
            MEM_WDATA_O <= '0;
            BUSY_O      <= 1'b0;
            DONE_O      <= 1'b0;
        end else begin
            DONE_O <= 1'b0;
            case (state)
                IDLE: begin
                    // Commands read the registers as they were before this
                    // edge, so a capture in the same cycle affects only later
                    // operations.
                    if (CMD_ADDR_I) start_q <= ADDR_W'(SW_I);
                    if (CMD_END_I)  end_q   <= ADDR_W'(SW_I);
                    if (CMD_DATA_I) data_q  <= DATA_W'(SW_I);
                    if (CMD_FILL_I) begin
                        state       <= FILL;
                        MEM_WE_O    <= 1'b1;
                        BUSY_O      <= 1'b1;
                        MEM_ADDR_O  <= start_q;
                        MEM_WDATA_O <= pat_first;
                        pat_q       <= pat_first;
                        mode_q      <= MODE_I;
                        rem_q       <= end_q - start_q;
                        word_cnt_q  <= 16'd1;
`ifndef DEBUG_MEM_VERIFY_EN
                        DONE_O      <= (end_q == start_q);
`endif
                    end else if (CMD_WR_I) begin
                        state       <= WR1;
                        MEM_WE_O    <= 1'b1;
                        BUSY_O      <= 1'b1;
                        DONE_O      <= 1'b1;
                        MEM_ADDR_O  <= start_q;
                        MEM_WDATA_O <= data_q;
                    end else if (CMD_RD_I) begin
                        state      <= RD_WAIT;
                        BUSY_O     <= 1'b1;
                        MEM_ADDR_O <= start_q;
                        lat_cnt_q  <= LAT_W'(RD_LAT);
                    end
                end

                WR1: begin
                    state    <= IDLE;
                    MEM_WE_O <= 1'b0;
                    BUSY_O   <= 1'b0;
                end

                // The count reaches 0 in the cycle the read data is valid.
                // DONE is raised one edge early so that it lines up with
                // that cycle.
                RD_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        rd_reg_q <= MEM_RDATA_I;
                        state    <= IDLE;
                        BUSY_O   <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                        DONE_O    <= (lat_cnt_q == LAT_W'(1));
                    end
                end

                FILL: begin
                    if (rem_q == '0) begin
                        MEM_WE_O <= 1'b0;
`ifdef DEBUG_MEM_VERIFY_EN
                        state      <= VER_RUN;
                        MEM_ADDR_O <= start_q;
                        pat_q      <= first_pat(mode_q, data_q, start_q);
                        rem_q      <= end_q - start_q;
                        word_cnt_q <= 16'd1;
`else
                        state  <= IDLE;
                        BUSY_O <= 1'b0;
`endif
                    end else begin
                        MEM_ADDR_O  <= addr_nxt;
                        MEM_WDATA_O <= pat_nxt;
                        pat_q       <= pat_nxt;
                        rem_q       <= rem_q - ADDR_W'(1);
                        word_cnt_q  <= word_cnt_q + 16'd1;
`ifndef DEBUG_MEM_VERIFY_EN
                        DONE_O      <= (rem_q == ADDR_W'(1));
`endif
                    end
                end

`ifdef DEBUG_MEM_VERIFY_EN
                VER_RUN: begin
                    if (rem_q == '0) begin
                        state     <= VER_DRAIN;
                        lat_cnt_q <= LAT_W'(RD_LAT - 1);
                        DONE_O    <= (RD_LAT == 1);
                    end else begin
                        MEM_ADDR_O <= addr_nxt;
                        pat_q      <= pat_nxt;
                        rem_q      <= rem_q - ADDR_W'(1);
                        word_cnt_q <= word_cnt_q + 16'd1;
                    end
                end

                VER_DRAIN: begin
                    if (lat_cnt_q == '0) begin
                        state  <= IDLE;
                        BUSY_O <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                        DONE_O    <= (lat_cnt_q == LAT_W'(1));
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    MEM_WE_O <= 1'b0;
                    BUSY_O   <= 1'b0;
                end
            endcase

            if (ABORT_I && (state != IDLE)) begin
                state    <= IDLE;
                MEM_WE_O <= 1'b0;
                BUSY_O   <= 1'b0;
                DONE_O   <= 1'b0;
            end
        end
    end

`ifdef DEBUG_MEM_VERIFY_EN
    // Expected word and address for each read in flight. Stage RD_LAT-1 lines
    // up with the matching data on MEM_RDATA_I.
    logic              pv_q [RD_LAT];
    logic [DATA_W-1:0] pd_q [RD_LAT];
    logic [ADDR_W-1:0] pa_q [RD_LAT];
    logic              flush;
    logic              mismatch;

    assign flush    = ABORT_I && (state != IDLE);
    assign mismatch = pv_q[RD_LAT-1] && (MEM_RDATA_I != pd_q[RD_LAT-1]);

    always_ff @(posedge CLK_100_I) begin
        if (RST_I) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
                pa_q[i] <= '0;
            end
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            pv_q[0] <= (state == VER_RUN) && !flush;
            pd_q[0] <= pat_q;
            pa_q[0] <= MEM_ADDR_O;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1] && !flush;
                pd_q[i] <= pd_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
            if ((state == IDLE) && CMD_FILL_I) begin
                err_cnt_q   <= '0;
                first_err_q <= '0;
            end else if (mismatch) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                if (err_cnt_q == 16'h0000) first_err_q <= pa_q[RD_LAT-1];
            end
        end
    end
`else
    assign err_cnt_q   = '0;
    assign first_err_q = '0;
`endif

    always_ff @(posedge CLK_100_I) begin
        if (RST_I) begin
            DISP_O <= '0;
        end else begin
            case (DISP_SEL_I)
                2'b00:   DISP_O <= {16'(start_q), 16'(data_q)};
                2'b01:   DISP_O <= {16'(start_q), 16'(rd_reg_q)};
                2'b10:   DISP_O <= {16'(first_err_q), err_cnt_q};
                default: DISP_O <= {13'b0, 3'(state), word_cnt_q};
            endcase
        end
    end

endmodule

// File: tb/tb_debug_mem_ctrl.sv
module tb_debug_mem_ctrl;

    logic        CLK_100_I = 1'b0;
    logic        RST_I;
    logic [15:0] SW_I;
    logic        CMD_ADDR_I, CMD_END_I, CMD_DATA_I, CMD_WR_I, CMD_RD_I, CMD_FILL_I, ABORT_I;
    logic [1:0]  MODE_I, DISP_SEL_I;
    logic [15:0] MEM_RDATA_I;
    logic        MEM_WE_O;
    logic [15:0] MEM_ADDR_O, MEM_WDATA_O;
    logic        BUSY_O, DONE_O;
    logic [15:0] ERR_CNT_O;
    logic [31:0] DISP_O;

    int passed = 0;
    int total  = 0;

    // BRAM model, two-cycle read latency; optional corruption of address 0x0005
    logic [15:0] mem [65536];
    logic [15:0] rd_s1;
    logic        corrupt_en = 1'b0;

    // write / done monitor
    logic [15:0] log_a [64];
    logic [15:0] log_d [64];
    int          wr_n = 0;
    int          done_cnt = 0;
    logic [15:0] done_addr = '0;

    debug_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .SW_W(16), .RD_LAT(2)) dut (
        .CLK_100_I(CLK_100_I), .RST_I(RST_I), .SW_I(SW_I),
        .CMD_ADDR_I(CMD_ADDR_I), .CMD_END_I(CMD_END_I), .CMD_DATA_I(CMD_DATA_I),
        .CMD_WR_I(CMD_WR_I), .CMD_RD_I(CMD_RD_I), .CMD_FILL_I(CMD_FILL_I),
        .ABORT_I(ABORT_I), .MODE_I(MODE_I), .DISP_SEL_I(DISP_SEL_I),
        .MEM_RDATA_I(MEM_RDATA_I), .MEM_WE_O(MEM_WE_O), .MEM_ADDR_O(MEM_ADDR_O),
        .MEM_WDATA_O(MEM_WDATA_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O),
        .ERR_CNT_O(ERR_CNT_O), .DISP_O(DISP_O)
    );

    always #5 CLK_100_I = ~CLK_100_I;

    always @(posedge CLK_100_I) begin
        if (MEM_WE_O) mem[MEM_ADDR_O] <= MEM_WDATA_O;
        rd_s1       <= mem[MEM_ADDR_O] ^ ((corrupt_en && MEM_ADDR_O == 16'h0005) ? 16'h00FF : 16'h0000);
        MEM_RDATA_I <= rd_s1;
    end

    always @(negedge CLK_100_I) begin
        if (MEM_WE_O) begin
            if (wr_n < 64) begin
                log_a[wr_n] = MEM_ADDR_O;
                log_d[wr_n] = MEM_WDATA_O;
            end
            wr_n = wr_n + 1;
        end
        if (DONE_O) begin
            done_cnt  = done_cnt + 1;
            done_addr = MEM_ADDR_O;
        end
    end

    task automatic cyc();
        @(posedge CLK_100_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic capture(input int which, input logic [15:0] val);
        SW_I = val;
        CMD_ADDR_I = (which == 0);
        CMD_END_I  = (which == 1);
        CMD_DATA_I = (which == 2);
        cyc();
        CMD_ADDR_I = 1'b0;
        CMD_END_I  = 1'b0;
        CMD_DATA_I = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && BUSY_O; i++) cyc();
        chk(tag, {31'b0, BUSY_O}, 32'd0);
    endtask

    initial begin
        RST_I = 1'b1;
        SW_I = '0;
        CMD_ADDR_I = 0; CMD_END_I = 0; CMD_DATA_I = 0;
        CMD_WR_I = 0; CMD_RD_I = 0; CMD_FILL_I = 0; ABORT_I = 0;
        MODE_I = 2'b00; DISP_SEL_I = 2'b00;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        rd_s1 = '0;
        MEM_RDATA_I = '0;
        cyc(); cyc(); cyc();

        // reset state
        chk("rst_we",    {31'b0, MEM_WE_O}, 0);
        chk("rst_addr",  {16'b0, MEM_ADDR_O}, 0);
        chk("rst_wdata", {16'b0, MEM_WDATA_O}, 0);
        chk("rst_busy",  {31'b0, BUSY_O}, 0);
        chk("rst_done",  {31'b0, DONE_O}, 0);
        chk("rst_err",   {16'b0, ERR_CNT_O}, 0);
        chk("rst_disp",  DISP_O, 0);
        RST_I = 1'b0;
        cyc();

        // single write
        capture(0, 16'h0010);
        capture(2, 16'hBEEF);
        cyc();
        chk("disp_start_data", DISP_O, 32'h0010BEEF);
        wr_n = 0; done_cnt = 0;
        CMD_WR_I = 1'b1;
        cyc();
        CMD_WR_I = 1'b0;
        chk("wr_we",    {31'b0, MEM_WE_O}, 1);
        chk("wr_addr",  {16'b0, MEM_ADDR_O}, 32'h0010);
        chk("wr_wdata", {16'b0, MEM_WDATA_O}, 32'hBEEF);
        chk("wr_done",  {31'b0, DONE_O}, 1);
        chk("wr_busy",  {31'b0, BUSY_O}, 1);
        cyc();
        chk("wr_we_after",   {31'b0, MEM_WE_O}, 0);
        chk("wr_busy_after", {31'b0, BUSY_O}, 0);
        chk("wr_addr_hold",  {16'b0, MEM_ADDR_O}, 32'h0010);
        chk("wr_count",      wr_n, 1);

        // single read, RD_LAT = 2; data register changed so rd_reg is distinguishable
        capture(2, 16'h1234);
        DISP_SEL_I = 2'b01;
        done_cnt = 0;
        CMD_RD_I = 1'b1;
        cyc();
        CMD_RD_I = 1'b0;
        chk("rd_addr", {16'b0, MEM_ADDR_O}, 32'h0010);
        chk("rd_busy", {31'b0, BUSY_O}, 1);
        chk("rd_we",   {31'b0, MEM_WE_O}, 0);
        cyc();
        chk("rd_done_early", {31'b0, DONE_O}, 0);
        cyc();
        chk("rd_done", {31'b0, DONE_O}, 1);
        cyc();
        chk("rd_busy_after", {31'b0, BUSY_O}, 0);
        cyc();
        chk("rd_disp", DISP_O, 32'h0010BEEF);
        chk("rd_done_cnt", done_cnt, 1);

        // wrapping incrementing fill FFFE..0001
        DISP_SEL_I = 2'b11;
        capture(0, 16'hFFFE);
        capture(1, 16'h0001);
        capture(2, 16'hFFFF);
        MODE_I = 2'b01;
        wr_n = 0; done_cnt = 0;
        CMD_FILL_I = 1'b1;
        cyc();
        CMD_FILL_I = 1'b0;
        wait_idle("wrap_timeout");
        cyc();
        chk("wrap_count", wr_n, 4);
        chk("wrap_a0", {16'b0, log_a[0]}, 32'hFFFE);
        chk("wrap_d0", {16'b0, log_d[0]}, 32'hFFFF);
        chk("wrap_a1", {16'b0, log_a[1]}, 32'hFFFF);
        chk("wrap_d1", {16'b0, log_d[1]}, 32'h0000);
        chk("wrap_a2", {16'b0, log_a[2]}, 32'h0000);
        chk("wrap_d2", {16'b0, log_d[2]}, 32'h0001);
        chk("wrap_a3", {16'b0, log_a[3]}, 32'h0001);
        chk("wrap_d3", {16'b0, log_d[3]}, 32'h0002);
        chk("wrap_done_cnt", done_cnt, 1);
        chk("wrap_done_addr", {16'b0, done_addr}, 32'h0001);
        chk("wrap_disp_state_cnt", DISP_O, 32'h00000004);

        // address-pattern fill aborted on the 10th write
        capture(0, 16'h0000);
        capture(1, 16'h00FF);
        MODE_I = 2'b10;
        wr_n = 0; done_cnt = 0;
        CMD_FILL_I = 1'b1;
        cyc();
        CMD_FILL_I = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        ABORT_I = 1'b1;
        cyc();
        ABORT_I = 1'b0;
        chk("abort_we",   {31'b0, MEM_WE_O}, 0);
        chk("abort_busy", {31'b0, BUSY_O}, 0);
        cyc(); cyc(); cyc();
        chk("abort_count", wr_n, 10);
        chk("abort_last_d", {16'b0, log_d[9]}, 32'h0009);
        chk("abort_no_done", done_cnt, 0);

        // FILL + WR + ADDR together: fill uses old start, new start captured
        capture(0, 16'h0100);
        capture(1, 16'h0102);
        capture(2, 16'h5555);
        MODE_I = 2'b00;
        DISP_SEL_I = 2'b00;
        wr_n = 0; done_cnt = 0;
        SW_I = 16'h0200;
        CMD_FILL_I = 1'b1; CMD_WR_I = 1'b1; CMD_ADDR_I = 1'b1;
        cyc();
        CMD_FILL_I = 1'b0; CMD_WR_I = 1'b0; CMD_ADDR_I = 1'b0;
        wait_idle("prio_timeout");
        cyc();
        chk("prio_count", wr_n, 3);
        chk("prio_a0", {16'b0, log_a[0]}, 32'h0100);
        chk("prio_a2", {16'b0, log_a[2]}, 32'h0102);
        chk("prio_d1", {16'b0, log_d[1]}, 32'h5555);
        chk("prio_disp", DISP_O, 32'h02005555);
        chk("prio_done_cnt", done_cnt, 1);

        // single-word fill, start == end
        capture(0, 16'h0300);
        capture(1, 16'h0300);
        wr_n = 0; done_cnt = 0;
        CMD_FILL_I = 1'b1;
        cyc();
        CMD_FILL_I = 1'b0;
        wait_idle("one_timeout");
        cyc();
        chk("one_count", wr_n, 1);
        chk("one_done_cnt", done_cnt, 1);

`ifdef DEBUG_MEM_VERIFY_EN
        // verify catches the corrupted word at 0x0005
        capture(0, 16'h0000);
        capture(1, 16'h000F);
        capture(2, 16'hA5A5);
        MODE_I = 2'b00;
        DISP_SEL_I = 2'b10;
        corrupt_en = 1'b1;
        done_cnt = 0;
        CMD_FILL_I = 1'b1;
        cyc();
        CMD_FILL_I = 1'b0;
        wait_idle("ver_timeout");
        cyc();
        chk("ver_err_cnt", {16'b0, ERR_CNT_O}, 32'd1);
        chk("ver_disp", DISP_O, 32'h00050001);
        chk("ver_done_cnt", done_cnt, 1);
        corrupt_en = 1'b0;
`endif

        // reset in the middle of a fill
        capture(0, 16'h0000);
        capture(1, 16'h00FF);
        done_cnt = 0;
        CMD_FILL_I = 1'b1;
        cyc();
        CMD_FILL_I = 1'b0;
        cyc(); cyc();
        RST_I = 1'b1;
        cyc();
        chk("mrst_we",   {31'b0, MEM_WE_O}, 0);
        chk("mrst_busy", {31'b0, BUSY_O}, 0);
        chk("mrst_addr", {16'b0, MEM_ADDR_O}, 0);
        chk("mrst_disp", DISP_O, 0);
        chk("mrst_done", done_cnt, 0);
        RST_I = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
